border_discovery_ctrl: RTL and testbench

- Per-router sequencer for the border-discovery phase of the mesh.
- Drives the 3-bit phase code consumed by the border checker (000 = init, 100 = collect).
- Announces the node's own coordinates to every existing neighbour using a valid/ready handshake.
- Arbitrates simultaneous incoming announce flits so that exactly one flit per cycle reaches the checker, and declares done, or error on timeout.

---
 rtl/border_discovery_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_border_discovery_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/border_discovery_ctrl.sv
// border_discovery_ctrl
// ---------------------
// This is the per-router sequencer for the mesh border-discovery phase.
// It steps through IDLE, ANNOUNCE, COLLECT and then DONE or ERROR, and it
// presents the current phase code to the border checker on 'state'.
//
// During ANNOUNCE the node sends its own coordinates once to every
// neighbour that exists, using a valid/ready handshake for each direction.
// During COLLECT it accepts incoming announce flits one per cycle, using a
// fixed N > E > S > W priority, and forwards the granted flit to the checker.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   start, clear         start discovery (IDLE only) / return to IDLE
//                        (DONE/ERROR only)
//   my_x, my_y           node coordinates
//   get_border           completion flag from the border checker
//   {n,e,s,w}_out_valid  announce flit valid, one per direction
//   {n,e,s,w}_out_ready  neighbour accepts the announce flit
//   ann_flit             announce flit, shared by all directions
//   {n,e,s,w}_in_valid   incoming flit valid
//   {n,e,s,w}_in_data    incoming flit data
//   {n,e,s,w}_in_ready   incoming flit accepted this cycle (at most one)
//   chk_{n,e,s,w}        checker inputs; only the granted one is nonzero
//   state                phase code: 000 idle, 001 announce, 100 collect,
//                        010 done, 011 error
//   rx_count             number of accepted flits, saturating at 31
//   done, error          registered completion / timeout flags

`ifndef T_D_WIDTH
`define T_D_WIDTH 32
`endif

module border_discovery_ctrl #(
   parameter int WIDTHX  = 6,
   parameter int WIDTHY  = 6,
   parameter int TIMEOUT = 1023,
   parameter int EXPECT  = (WIDTHX + WIDTHY) * 2 - 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    clear,
   input  logic [2:0]              my_x,
   input  logic [2:0]              my_y,
   input  logic                    get_border,
   output logic                    n_out_valid,
   output logic                    e_out_valid,
   output logic                    s_out_valid,
   output logic                    w_out_valid,
   input  logic                    n_out_ready,
   input  logic                    e_out_ready,
   input  logic                    s_out_ready,
   input  logic                    w_out_ready,
   output logic [`T_D_WIDTH-1:0]   ann_flit,
   input  logic                    n_in_valid,
   input  logic                    e_in_valid,
   input  logic                    s_in_valid,
   input  logic                    w_in_valid,
   input  logic [`T_D_WIDTH-1:0]   n_in_data,
   input  logic [`T_D_WIDTH-1:0]   e_in_data,
   input  logic [`T_D_WIDTH-1:0]   s_in_data,
   input  logic [`T_D_WIDTH-1:0]   w_in_data,
   output logic                    n_in_ready,
   output logic                    e_in_ready,
   output logic                    s_in_ready,
   output logic                    w_in_ready,
   output logic [`T_D_WIDTH-1:0]   chk_n,
   output logic [`T_D_WIDTH-1:0]   chk_e,
   output logic [`T_D_WIDTH-1:0]   chk_s,
   output logic [`T_D_WIDTH-1:0]   chk_w,
   output logic [2:0]              state,
   output logic [4:0]              rx_count,
   output logic                    done,
   output logic                    error
);

   localparam logic [2:0] S_IDLE     = 3'b000;
   localparam logic [2:0] S_ANNOUNCE = 3'b001;
   localparam logic [2:0] S_COLLECT  = 3'b100;
   localparam logic [2:0] S_DONE     = 3'b010;
   localparam logic [2:0] S_ERROR    = 3'b011;

   localparam logic [2:0] MAX_X     = 3'(WIDTHX - 1);
   localparam logic [2:0] MAX_Y     = 3'(WIDTHY - 1);
   localparam logic [4:0] EXPECT_C  = 5'(EXPECT);
   localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

   // Direction vectors use bit 0 for N, bit 1 for E, bit 2 for S and bit 3 for W.
   logic [3:0] exists;
   logic [3:0] pending;
   logic [3:0] out_ready;
   logic [3:0] grant;
   logic [9:0] timer;
   logic [2:0] state_nxt;
   logic       done_cond;

   assign exists    = {(my_x != 3'd0), (my_y < MAX_Y), (my_x < MAX_X), (my_y != 3'd0)};
   assign out_ready = {w_out_ready, s_out_ready, e_out_ready, n_out_ready};

   // pending is only ever nonzero in ANNOUNCE, so it can drive the valids directly.
   // A pending bit clears only on a completed handshake, so a valid is never
   // withdrawn before its ready arrives.
   assign n_out_valid = pending[0];
   assign e_out_valid = pending[1];
   assign s_out_valid = pending[2];
   assign w_out_valid = pending[3];

   // Bit 13 is a marker bit, so that node (0,0) still produces a nonzero flit.
   always_comb begin
      ann_flit        = '0;
      ann_flit[25:13] = {my_x, my_y, my_x, my_y, 1'b1};
   end

   // Fixed-priority grant N > E > S > W. It is only active in COLLECT.
   always_comb begin
      grant = 4'b0000;
      if (state == S_COLLECT) begin
         if (n_in_valid)      grant[0] = 1'b1;
         else if (e_in_valid) grant[1] = 1'b1;
         else if (s_in_valid) grant[2] = 1'b1;
         else if (w_in_valid) grant[3] = 1'b1;
      end
   end

   assign n_in_ready = grant[0];
   assign e_in_ready = grant[1];
   assign s_in_ready = grant[2];
   assign w_in_ready = grant[3];

   assign chk_n = grant[0] ? n_in_data : '0;
   assign chk_e = grant[1] ? e_in_data : '0;
   assign chk_s = grant[2] ? s_in_data : '0;
   assign chk_w = grant[3] ? w_in_data : '0;

   // The completion test uses the registered count. If the timeout falls in
   // the same cycle, completion takes precedence over the timeout.
   assign done_cond = get_border || (rx_count >= EXPECT_C);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start) state_nxt = S_ANNOUNCE;
         S_ANNOUNCE: if (pending == 4'b0000) state_nxt = S_COLLECT;
         S_COLLECT: begin
            if (done_cond)               state_nxt = S_DONE;
            else if (timer == TIMEOUT_C) state_nxt = S_ERROR;
         end
         S_DONE, S_ERROR: if (clear) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         pending  <= 4'b0000;
         rx_count <= 5'd0;
         timer    <= 10'd0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state_nxt == S_DONE);
         error <= (state_nxt == S_ERROR);
         case (state)
            S_IDLE: begin
               if (start) begin
                  pending  <= exists;
                  rx_count <= 5'd0;
                  timer    <= 10'd0;
               end
            end
            S_ANNOUNCE: pending <= pending & ~out_ready;
            S_COLLECT: begin
               if ((grant != 4'b0000) && (rx_count != 5'd31)) rx_count <= rx_count + 5'd1;
               if (timer != TIMEOUT_C) timer <= timer + 10'd1;
            end
            S_DONE, S_ERROR: begin
               if (clear) begin
                  rx_count <= 5'd0;
                  timer    <= 10'd0;
               end
            end
            default: pending <= 4'b0000;
         endcase
      end
   end

endmodule

// File: tb/tb_border_discovery_ctrl.sv
`ifndef T_D_WIDTH
`define T_D_WIDTH 32
`endif

module tb_border_discovery_ctrl;

   localparam int DW = `T_D_WIDTH;

   logic          clk = 1'b0;
   logic          reset, start, clear, get_border;
   logic [2:0]    my_x, my_y;
   logic          n_out_valid, e_out_valid, s_out_valid, w_out_valid;
   logic          n_out_ready, e_out_ready, s_out_ready, w_out_ready;
   logic [DW-1:0] ann_flit;
   logic          n_in_valid, e_in_valid, s_in_valid, w_in_valid;
   logic [DW-1:0] n_in_data, e_in_data, s_in_data, w_in_data;
   logic          n_in_ready, e_in_ready, s_in_ready, w_in_ready;
   logic [DW-1:0] chk_n, chk_e, chk_s, chk_w;
   logic [2:0]    state;
   logic [4:0]    rx_count;
   logic          done, error;

   int checks = 0;
   int errors = 0;
   int coll_cyc = 0;

   typedef struct {
      logic [3:0]    dir;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   border_discovery_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .clear(clear),
      .my_x(my_x), .my_y(my_y), .get_border(get_border),
      .n_out_valid(n_out_valid), .e_out_valid(e_out_valid),
      .s_out_valid(s_out_valid), .w_out_valid(w_out_valid),
      .n_out_ready(n_out_ready), .e_out_ready(e_out_ready),
      .s_out_ready(s_out_ready), .w_out_ready(w_out_ready),
      .ann_flit(ann_flit),
      .n_in_valid(n_in_valid), .e_in_valid(e_in_valid),
      .s_in_valid(s_in_valid), .w_in_valid(w_in_valid),
      .n_in_data(n_in_data), .e_in_data(e_in_data),
      .s_in_data(s_in_data), .w_in_data(w_in_data),
      .n_in_ready(n_in_ready), .e_in_ready(e_in_ready),
      .s_in_ready(s_in_ready), .w_in_ready(w_in_ready),
      .chk_n(chk_n), .chk_e(chk_e), .chk_s(chk_s), .chk_w(chk_w),
      .state(state), .rx_count(rx_count), .done(done), .error(error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      coll_cyc++;
   endtask

   function automatic logic [3:0] out_valids();
      return {w_out_valid, s_out_valid, e_out_valid, n_out_valid};
   endfunction

   function automatic logic [3:0] in_readys();
      return {w_in_ready, s_in_ready, e_in_ready, n_in_ready};
   endfunction

   task automatic set_in(input logic [3:0] v);
      n_in_valid = v[0];
      e_in_valid = v[1];
      s_in_valid = v[2];
      w_in_valid = v[3];
   endtask

   task automatic set_out_ready(input logic [3:0] r);
      n_out_ready = r[0];
      e_out_ready = r[1];
      s_out_ready = r[2];
      w_out_ready = r[3];
   endtask

   // Pop the next expected grant and compare it with the ready/chk outputs.
   task automatic check_grant(output logic [3:0] dir);
      exp_t e;
      dir = 4'b0000;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_empty: observed grant %0h expected none queued", in_readys());
      end else begin
         e = sb.pop_front();
         dir = e.dir;
         chk("grant_ready", {28'd0, in_readys()}, {28'd0, e.dir});
         chk("chk_n", chk_n, e.dir[0] ? e.data : '0);
         chk("chk_e", chk_e, e.dir[1] ? e.data : '0);
         chk("chk_s", chk_s, e.dir[2] ? e.data : '0);
         chk("chk_w", chk_w, e.dir[3] ? e.data : '0);
      end
   endtask

   initial begin
      logic [3:0]    d;
      logic [DW-1:0] v;
      reset = 1'b0; start = 1'b0; clear = 1'b0; get_border = 1'b0;
      my_x = 3'd0; my_y = 3'd0;
      set_out_ready(4'b1111);
      set_in(4'b0000);
      n_in_data = 32'h11; e_in_data = 32'h22; s_in_data = 32'h33; w_in_data = 32'h44;

      // Reset state; in IDLE, incoming flits must not be accepted.
      repeat (2) tick();
      reset = 1'b1;
      set_in(4'b1111);
      #1;
      chk("rst_state", {29'd0, state}, 32'd0);
      chk("rst_out_valid", {28'd0, out_valids()}, 32'd0);
      chk("rst_in_ready", {28'd0, in_readys()}, 32'd0);
      chk("rst_chk", chk_n | chk_e | chk_s | chk_w, 32'd0);
      chk("rst_rx_count", {27'd0, rx_count}, 32'd0);
      chk("rst_done_error", {30'd0, done, error}, 32'd0);
      set_in(4'b0000);

      // Node (0,0): only E and S exist. With all readys high, COLLECT is
      // reached two cycles after start.
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      chk("a00_state", {29'd0, state}, 32'h1);
      chk("a00_valids", {28'd0, out_valids()}, 32'h6);
      chk("a00_flit", ann_flit, 32'h2000);
      tick();
      chk("a00_state2", {29'd0, state}, 32'h1);
      chk("a00_valids2", {28'd0, out_valids()}, 32'h0);
      tick();
      chk("a00_collect", {29'd0, state}, 32'h4);
      coll_cyc = 0;

      // All four directions request at once; grants are N, E, S, W.
      n_in_data = 32'hA1; e_in_data = 32'hB2; s_in_data = 32'hC3; w_in_data = 32'hD4;
      sb.push_back('{4'b0001, 32'hA1});
      sb.push_back('{4'b0010, 32'hB2});
      sb.push_back('{4'b0100, 32'hC3});
      sb.push_back('{4'b1000, 32'hD4});
      set_in(4'b1111);
      for (int k = 0; k < 4; k++) begin
         #1;
         check_grant(d);
         tick();
         set_in({w_in_valid, s_in_valid, e_in_valid, n_in_valid} & ~d);
      end
      set_in(4'b0000);
      chk("four_rx_count", {27'd0, rx_count}, 32'd4);
      chk("four_state", {29'd0, state}, 32'h4);

      // With no further flits, the timeout expires at timer == 1023.
      while (coll_cyc < 1023) tick();
      chk("to_pre_state", {29'd0, state}, 32'h4);
      chk("to_pre_error", {31'd0, error}, 32'd0);
      tick();
      chk("to_state", {29'd0, state}, 32'h3);
      chk("to_error", {30'd0, done, error}, 32'h1);
      set_in(4'b1111);
      #1;
      chk("to_no_ready", {28'd0, in_readys()}, 32'd0);
      set_in(4'b0000);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("to_clear_state", {29'd0, state}, 32'h0);
      chk("to_clear_flags", {27'd0, rx_count, done, error}, 32'd0);

      // Reset while ANNOUNCE is in progress at node (2,3).
      my_x = 3'd2; my_y = 3'd3;
      set_out_ready(4'b0000);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("mid_state", {29'd0, state}, 32'h1);
      chk("mid_n_valid", {31'd0, n_out_valid}, 32'h1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mid_rst_state", {29'd0, state}, 32'h0);
      chk("mid_rst_valids", {28'd0, out_valids()}, 32'h0);
      chk("mid_rst_rx", {27'd0, rx_count}, 32'd0);

      // Node (2,3): E ready is held low for 5 cycles.
      set_out_ready(4'b1101);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("e_state1", {29'd0, state}, 32'h1);
      chk("e_valids1", {28'd0, out_valids()}, 32'hF);
      chk("e_flit1", ann_flit, 32'h0134E000);
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk("e_hold_state", {29'd0, state}, 32'h1);
         chk("e_hold_valids", {28'd0, out_valids()}, 32'h2);
         chk("e_hold_flit", ann_flit, 32'h0134E000);
      end
      e_out_ready = 1'b1;
      tick();
      chk("e_done_state", {29'd0, state}, 32'h1);
      chk("e_done_valids", {28'd0, out_valids()}, 32'h0);
      tick();
      chk("e_collect", {29'd0, state}, 32'h4);
      coll_cyc = 0;

      // Deliver 20 flits in rotating directions; EXPECT = 20 for a 6x6 mesh.
      for (int i = 0; i < 20; i++) begin
         d = 4'b0001 << (i % 4);
         v = $urandom | 32'h1;
         n_in_data = v; e_in_data = v; s_in_data = v; w_in_data = v;
         sb.push_back('{d, v});
         set_in(d);
         #1;
         check_grant(d);
         tick();
         set_in(4'b0000);
      end
      chk("d20_rx", {27'd0, rx_count}, 32'd20);
      chk("d20_state_pre", {29'd0, state}, 32'h4);
      tick();
      chk("d20_state", {29'd0, state}, 32'h2);
      chk("d20_flags", {30'd0, done, error}, 32'h2);
      set_in(4'b1111);
      start = 1'b1;
      #1;
      chk("d20_no_ready", {28'd0, in_readys()}, 32'd0);
      tick();
      start = 1'b0;
      set_in(4'b0000);
      chk("d20_start_ignored", {29'd0, state}, 32'h2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("d20_clear_state", {29'd0, state}, 32'h0);
      chk("d20_clear_flags", {27'd0, rx_count, done, error}, 32'd0);

      // get_border is raised in the same cycle as the timeout; DONE must win.
      set_out_ready(4'b1111);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("gb_collect", {29'd0, state}, 32'h4);
      coll_cyc = 0;
      while (coll_cyc < 1023) tick();
      chk("gb_pre_state", {29'd0, state}, 32'h4);
      get_border = 1'b1;
      tick();
      get_border = 1'b0;
      chk("gb_state", {29'd0, state}, 32'h2);
      chk("gb_flags", {30'd0, done, error}, 32'h2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("gb_clear_state", {29'd0, state}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
